// File: rtl/lc3b_evict_write_buffer.sv
`default_nettype none
// ============================================================================
// lc3b_evict_write_buffer : FIFO of evicted dirty lines drained to pmem,
// with merging of repeated evictions and forwarding to L1 refills.  Rev 1.0
// ============================================================================
module lc3b_evict_write_buffer #(
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 4,
    parameter int DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] enq_laddr,
    input  logic [LINE_WIDTH-1:0]         enq_data,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] lkp_laddr,
    output logic                          lkp_hit,
    output logic [LINE_WIDTH-1:0]         lkp_data,
    output logic                          pmem_write,
    output logic [ADDR_WIDTH-1:0]         pmem_address,
    output logic [LINE_WIDTH-1:0]         pmem_wdata,
    input  logic                          pmem_resp,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    output logic                          full
);

    localparam int LADDR_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);

    typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t                 state, state_nx;
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       cnt;
    logic [DEPTH-1:0]       valid;
    logic [LADDR_W-1:0]     laddr_q [DEPTH];
    logic [LINE_WIDTH-1:0]  data_q  [DEPTH];

    logic                   match, hit, do_append, do_merge, do_pop;
    logic [PTR_W-1:0]       match_idx, hit_idx;

    // Scan oldest to newest so the last match found is the newest entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        match     = 1'b0;
        match_idx = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && laddr_q[idx] == enq_laddr &&
                !(state == WRITE && idx == head)) begin
                match     = 1'b1;
                match_idx = idx;
            end
            if (valid[idx] && laddr_q[idx] == lkp_laddr) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign count     = cnt;
    assign enq_ready = !full || match;
    assign do_merge  = enq_valid && match;
    assign do_append = enq_valid && !match && !full;

    assign lkp_hit      = hit;
    assign lkp_data     = data_q[hit_idx];
    assign pmem_write   = (state == WRITE);
    assign pmem_address = {laddr_q[head], {OFFSET_BITS{1'b0}}};
    assign pmem_wdata   = data_q[head];

    always_comb begin
        state_nx = state;
        do_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nx = WRITE;
            end
            WRITE: begin
                if (pmem_resp) begin
                    do_pop   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            if (do_append) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({do_append, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_append) begin
            laddr_q[tail] <= enq_laddr;
            data_q[tail]  <= enq_data;
        end else if (do_merge) begin
            data_q[match_idx] <= enq_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_evict_write_buffer.sv
`default_nettype none
// ============================================================================
// tb_lc3b_evict_write_buffer : directed scenarios plus random traffic checked
// against a queue-based reference model.  Rev 1.0
// ============================================================================
module tb_lc3b_evict_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enq_valid = 1'b0;
    logic         enq_ready;
    logic [11:0]  enq_laddr = '0;
    logic [127:0] enq_data = '0;
    logic [11:0]  lkp_laddr = '0;
    logic         lkp_hit;
    logic [127:0] lkp_data;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [2:0]   count;
    logic         empty;
    logic         full;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_evict_write_buffer #(
        .LINE_WIDTH(128), .ADDR_WIDTH(16), .OFFSET_BITS(4), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_laddr(enq_laddr), .enq_data(enq_data),
        .lkp_laddr(lkp_laddr), .lkp_hit(lkp_hit), .lkp_data(lkp_data),
        .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a queue of lines, front is oldest.
    typedef struct {
        logic [11:0]  la;
        logic [127:0] d;
    } ent_t;
    ent_t mq[$];
    bit   m_inflight = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_merge_idx(input logic [11:0] la);
        int r = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].la == la && !(i == 0 && m_inflight)) r = i;
        return r;
    endfunction

    function automatic int m_lookup(input logic [11:0] la);
        int r = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].la == la) r = i;
        return r;
    endfunction

    // Model update at each active edge, on pre-edge inputs and state.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_inflight = 1'b0;
        end else begin
            int  mi;
            int  pre_size;
            bit  pop;
            pre_size = mq.size();
            mi       = m_merge_idx(enq_laddr);
            pop      = m_inflight && pmem_resp;
            if (enq_valid) begin
                if (mi >= 0) mq[mi].d = enq_data;
                else if (pre_size < DEPTH) mq.push_back('{la: enq_laddr, d: enq_data});
            end
            if (pop) begin
                void'(mq.pop_front());
                m_inflight = 1'b0;
            end else if (!m_inflight && pre_size > 0) begin
                m_inflight = 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            int li;
            chk("pmem_write", 128'(pmem_write), 128'(m_inflight));
            chk("count", 128'(count), 128'(mq.size()));
            chk("empty", 128'(empty), 128'(mq.size() == 0));
            chk("full", 128'(full), 128'(mq.size() == DEPTH));
            if (enq_valid)
                chk("enq_ready", 128'(enq_ready),
                    128'(mq.size() < DEPTH || m_merge_idx(enq_laddr) >= 0));
            li = m_lookup(lkp_laddr);
            chk("lkp_hit", 128'(lkp_hit), 128'(li >= 0));
            if (li >= 0) chk("lkp_data", lkp_data, mq[li].d);
            if (m_inflight && pmem_resp && mq.size() > 0) begin
                chk("pmem_address", 128'(pmem_address), 128'({mq[0].la, 4'h0}));
                chk("pmem_wdata", pmem_wdata, mq[0].d);
            end
        end
    end

    task automatic cyc(input logic v, input logic [11:0] la, input logic [127:0] d,
                       input logic r, input logic [11:0] lk);
        enq_valid = v;
        enq_laddr = la;
        enq_data  = d;
        pmem_resp = r;
        lkp_laddr = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(mq.size() == 0 && !m_inflight) && n < 40) begin
            cyc(1'b0, 12'h0, '0, 1'b1, 12'h0);
            n++;
        end
        if (n >= 40) chk("drain_timeout", 128'(mq.size()), 128'(0));
        cyc(1'b0, 12'h0, '0, 1'b0, 12'h0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] da, db, dc, de;
        da = 128'hA; db = 128'hB; dc = 128'hC; de = 128'hE;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_lkp_hit", 128'(lkp_hit), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single line round trip
        cyc(1'b1, 12'h123, 128'hD0, 1'b0, 12'h123);
        chk("first_count", 128'(count), 128'(1));
        chk("first_no_write_yet", 128'(pmem_write), 128'(0));
        cyc(1'b0, 12'h0, '0, 1'b0, 12'h0);
        chk("first_write", 128'(pmem_write), 128'(1));
        chk("first_addr", 128'(pmem_address), 128'(16'h1230));
        cyc(1'b0, 12'h0, '0, 1'b1, 12'h0);
        chk("first_empty", 128'(empty), 128'(1));

        // Fill to full, then probe readiness combinationally
        for (int i = 1; i <= 4; i++) cyc(1'b1, 12'(i), rnd128(), 1'b0, 12'h0);
        cyc(1'b0, 12'h0, '0, 1'b0, 12'h0);
        chk("fill_full", 128'(full), 128'(1));
        enq_valid = 1'b1; enq_laddr = 12'h0AA; #1;
        chk("full_new_ready", 128'(enq_ready), 128'(0));
        enq_laddr = 12'h003; #1;
        chk("full_merge_ready", 128'(enq_ready), 128'(1));
        enq_laddr = 12'h001; #1;
        chk("full_head_ready", 128'(enq_ready), 128'(0));
        drain();

        // Coalesce behind the in-flight head
        cyc(1'b1, 12'h010, da, 1'b0, 12'h0);
        cyc(1'b1, 12'h020, db, 1'b0, 12'h0);
        cyc(1'b1, 12'h020, dc, 1'b0, 12'h020);
        chk("coal_count", 128'(count), 128'(2));
        chk("coal_lkp", lkp_data, dc);
        drain();

        // Head duplicate is appended; in-flight data stays put
        cyc(1'b1, 12'h010, da, 1'b0, 12'h0);
        cyc(1'b0, 12'h0, '0, 1'b0, 12'h0);
        cyc(1'b1, 12'h010, de, 1'b0, 12'h010);
        chk("hdup_count", 128'(count), 128'(2));
        chk("hdup_wdata", pmem_wdata, da);
        chk("hdup_lkp", lkp_data, de);
        drain();

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 12'(12'h100 + i), rnd128(), 1'b0, 12'h0);
            drain();
        end

        // Append and pop in the same cycle
        cyc(1'b1, 12'h031, rnd128(), 1'b0, 12'h0);
        cyc(1'b1, 12'h032, rnd128(), 1'b0, 12'h0);
        cyc(1'b1, 12'h033, rnd128(), 1'b1, 12'h0);
        chk("same_cycle_count", 128'(count), 128'(2));
        drain();

        // Reset in the middle of a write
        cyc(1'b1, 12'h055, rnd128(), 1'b0, 12'h0);
        cyc(1'b0, 12'h0, '0, 1'b0, 12'h0);
        rst_n = 1'b0; #1;
        chk("midrst_write", 128'(pmem_write), 128'(0));
        chk("midrst_empty", 128'(empty), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic on a small address set to exercise merging
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 5)), rnd128(),
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 5)));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
